bimodal_btb_predictor: RTL

BIMODAL_BTB_PREDICTOR -- requirements
Module: bimodal_btb_predictor

---
 rtl/bimodal_btb_predictor.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bimodal_btb_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB (tag, target, counter).
// Optional statistics outputs are enabled with the BP_STATS_EN macro.
module bimodal_btb_predictor #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        predictor_en,
    input  logic [31:0] pc_IF,
    input  logic [31:0] instr_IF,
    input  logic [31:0] pc_EX,
    input  logic [31:0] instr_EX,
    input  logic        pc_sel_EX,
    input  logic [31:0] aludata_EX,
    input  logic        pred_taken_EX,
    input  logic [31:0] pred_target_EX,
    output logic        hit,
    output logic        flush_br,
    output logic [31:0] npc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mispredict_count
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_MAX ^ (CNT_MAX >> 1);
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_MAX >> 1;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             active, if_br, ex_br;
    logic             if_taken, ex_match;
    logic             mispredict, train, tgt_wr;
    logic [CNT_W-1:0] cnt_cur, cnt_d;

    logic unused_bits;
    assign unused_bits = ^{instr_IF[31:7], instr_EX[31:7], pc_IF[1:0]};

    assign if_idx = pc_IF[IDX_W+1:2];
    assign if_tag = pc_IF[31:IDX_W+2];
    assign ex_idx = pc_EX[IDX_W+1:2];
    assign ex_tag = pc_EX[31:IDX_W+2];

    assign active = predictor_en & ~rst_i;
    assign if_br  = (instr_IF[6:0] == OP_BR);
    assign ex_br  = (instr_EX[6:0] == OP_BR);

    // Lookup reads the registered table only, so a same-cycle write is not seen.
    assign if_taken = if_br & valid_q[if_idx]
                    & (tag_q[if_idx] == if_tag)
                    & cnt_q[if_idx][CNT_W-1];

    assign mispredict = active & ex_br
                      & ((pc_sel_EX != pred_taken_EX)
                      | (pc_sel_EX & pred_taken_EX
                         & (pred_target_EX != aludata_EX)));

    assign train    = active & ex_br;
    assign ex_match = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
    assign cnt_cur  = cnt_q[ex_idx];
    assign tgt_wr   = ~ex_match | pc_sel_EX;

    // Redirect selection: an EX mispredict overrides the IF prediction.
    always_comb begin
        hit      = 1'b0;
        flush_br = 1'b0;
        npc      = pc_IF + 32'd4;
        if (mispredict) begin
            hit      = 1'b1;
            flush_br = 1'b1;
            npc      = pc_sel_EX ? aludata_EX : pc_EX + 32'd4;
        end else if (active && if_taken) begin
            hit = 1'b1;
            npc = target_q[if_idx];
        end
    end

    // Counter next value: allocate weak, otherwise saturating step.
    always_comb begin
        cnt_d = cnt_cur;
        if (!ex_match) begin
            cnt_d = pc_sel_EX ? WEAK_T : WEAK_NT;
        end else if (pc_sel_EX) begin
            if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + CNT_ONE;
        end else begin
            if (cnt_cur != '0) cnt_d = cnt_cur - CNT_ONE;
        end
    end

    // Table state: reset clears valid/counters; training writes one entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= '0;
            end
        end else if (train) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            cnt_q[ex_idx]   <= cnt_d;
            if (tgt_wr) target_q[ex_idx] <= aludata_EX;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q, mp_cnt_q;

    // Saturating event counters for resolved branches and mispredicts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (train && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict && mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign br_count         = br_cnt_q;
    assign mispredict_count = mp_cnt_q;
`endif

endmodule
